// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR test sequencer: state encoding, result codes
// and the default LFSR width.
package lfsr_pkg;

    localparam int DEF_SEED_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_ZERO_SEED = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
    localparam logic [1:0] ERR_LOCK_LOST = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear and reset both return it to zero.
module sat_counter
    import lfsr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/lfsr_test_ctrl.sv
// Sequencer above the LFSR generator/checker pair: seed load, soft reset,
// lock acquisition, a counted run of valid words, and a pass/fail verdict.
module lfsr_test_ctrl
    import lfsr_pkg::*;
#(
    parameter int SEED_W       = DEF_SEED_W,
    parameter int CNT_W        = 16,
    parameter int SR_CYCLES    = 2,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [SEED_W-1:0] i_seed,
    input  logic [CNT_W-1:0]  i_num_words,
    input  logic              i_lock,
    output logic [SEED_W-1:0] o_seed,
    output logic              o_soft_reset,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [1:0]        o_err,
    output logic [7:0]        o_loss_cnt
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SR_LAST = CNT_W'(SR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   words_q;
    logic               lock_q;
    logic               accept;
    logic               set_result;
    logic               res_pass;
    logic [1:0]         res_err;
    logic               loss_event;

    // A lock loss is a 1->0 step of i_lock while running; lock_q is held at 1
    // outside RUN so the first RUN cycle compares against a primed history.
    assign loss_event = (state == ST_RUN) && lock_q && !i_lock;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        accept     = 1'b0;
        set_result = 1'b0;
        res_pass   = 1'b0;
        res_err    = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    accept = 1'b1;
                    cnt_n  = '0;
                    if (i_seed == '0) begin
                        state_n    = ST_DONE;
                        set_result = 1'b1;
                        res_err    = ERR_ZERO_SEED;
                    end else begin
                        state_n = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (cnt == SR_LAST) begin
                    state_n = ST_WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a timeout expiring in the same cycle.
                if (i_lock) begin
                    if (words_q == '0) begin
                        state_n    = ST_DONE;
                        set_result = 1'b1;
                        res_pass   = 1'b1;
                    end else begin
                        state_n = ST_RUN;
                        cnt_n   = words_q;
                    end
                end else if (cnt == TO_LAST) begin
                    state_n    = ST_DONE;
                    set_result = 1'b1;
                    res_err    = ERR_TIMEOUT;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            ST_RUN: begin
                if (cnt == ONE) begin
                    state_n    = ST_DONE;
                    set_result = 1'b1;
                    if ((o_loss_cnt != '0) || loss_event) begin
                        res_err = ERR_LOCK_LOST;
                    end else begin
                        res_pass = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Verdict is registered on the edge into DONE so it is already valid
    // while o_done is high, then held until the next accepted start.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            words_q <= '0;
            o_seed  <= '0;
            o_pass  <= 1'b0;
            o_err   <= ERR_NONE;
            lock_q  <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            lock_q <= (state == ST_RUN) ? i_lock : 1'b1;
            if (accept) begin
                o_seed  <= i_seed;
                words_q <= i_num_words;
                o_pass  <= 1'b0;
                o_err   <= ERR_NONE;
            end
            if (set_result) begin
                o_pass <= res_pass;
                o_err  <= res_err;
            end
        end
    end

    sat_counter #(
        .W(8)
    ) u_loss_cnt (
        .clk (clk),
        .rst (i_rst),
        .clr (accept),
        .inc (loss_event),
        .cnt (o_loss_cnt)
    );

    assign o_soft_reset = (state == ST_LOAD);
    assign o_valid      = (state == ST_WAIT_LOCK) || (state == ST_RUN);
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = (state == ST_DONE);

endmodule

// File: tb/tb_lfsr_test_ctrl.sv
// Bench for lfsr_test_ctrl: a reactive checker-lock model plus an arithmetic
// prediction of phase lengths and verdict for each test request.
module tb_lfsr_test_ctrl;

    localparam int SR  = 2;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_seed = '0;
    logic [15:0] i_num_words = '0;
    logic        i_lock = 1'b0;
    logic [7:0]  o_seed;
    logic        o_soft_reset, o_valid, o_busy, o_done, o_pass;
    logic [1:0]  o_err;
    logic [7:0]  o_loss_cnt;

    int total = 0;
    int bad   = 0;

    lfsr_test_ctrl #(
        .SEED_W(8), .CNT_W(16), .SR_CYCLES(SR), .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_seed(i_seed),
        .i_num_words(i_num_words), .i_lock(i_lock), .o_seed(o_seed),
        .o_soft_reset(o_soft_reset), .o_valid(o_valid), .o_busy(o_busy),
        .o_done(o_done), .o_pass(o_pass), .o_err(o_err), .o_loss_cnt(o_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checker model: lock appears on the L-th valid cycle (L=0: never) and is
    // dropped for 3 cycles starting at RUN offsets d1/d2 (negative: none).
    function automatic logic lock_fn(int k, int L, int d1, int d2);
        int r;
        if (L == 0 || k < L - 1) return 1'b0;
        r = k - L;
        if (d1 >= 0 && r >= d1 && r < d1 + 3) return 1'b0;
        if (d2 >= 0 && r >= d2 && r < d2 + 3) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_test(input string name, input logic [7:0] seed, input int words,
                            input int L, input int d1, input int d2, input int restart_at);
        int e_sr, e_v, e_err, e_pass, e_loss;
        int sr_n, v_n, done_n, done_iter, iter;
        logic got_done;
        logic [7:0] seed_s, loss_s;
        logic [1:0] err_s;
        logic pass_s;
        // Reference outcome from the sequencing rules
        e_loss = 0;
        if (seed == 8'h00) begin
            e_sr = 0; e_v = 0; e_err = 1; e_pass = 0;
        end else if (L == 0 || L > TMO) begin
            e_sr = SR; e_v = TMO; e_err = 2; e_pass = 0;
        end else begin
            e_sr = SR; e_v = L + words;
            if (d1 >= 0 && d1 < words) e_loss++;
            if (d2 >= 0 && d2 < words) e_loss++;
            e_err  = (e_loss != 0) ? 3 : 0;
            e_pass = (e_loss == 0) ? 1 : 0;
        end
        sr_n = 0; v_n = 0; done_n = 0; done_iter = 0; iter = 0; got_done = 1'b0;
        seed_s = '0; loss_s = '0; err_s = '0; pass_s = 1'b0;
        i_seed = seed; i_num_words = 16'(words); i_start = 1'b1;
        i_lock = lock_fn(0, L, d1, d2);
        while (!got_done && iter < 600) begin
            @(posedge clk); #1;
            iter++;
            i_start = 1'b0;
            i_seed = 8'($urandom);
            i_num_words = 16'($urandom);
            if (o_soft_reset) sr_n++;
            if (o_done) begin
                done_n++; got_done = 1'b1; done_iter = iter;
                pass_s = o_pass; err_s = o_err; loss_s = o_loss_cnt; seed_s = o_seed;
            end
            if (o_valid && v_n == restart_at) i_start = 1'b1;
            i_lock = lock_fn(v_n, L, d1, d2);
            if (o_valid) v_n++;
        end
        i_start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (o_done) done_n++;
        end
        check({name, ".done_reached"}, 32'(got_done), 1);
        check({name, ".soft_reset_cycles"}, sr_n, e_sr);
        check({name, ".valid_cycles"}, v_n, e_v);
        check({name, ".done_pulses"}, done_n, 1);
        check({name, ".done_latency"}, done_iter, 1 + e_sr + e_v);
        check({name, ".pass"}, 32'(pass_s), e_pass);
        check({name, ".err"}, 32'(err_s), e_err);
        check({name, ".loss_cnt"}, 32'(loss_s), e_loss);
        check({name, ".seed_latched"}, 32'(seed_s), 32'(seed));
        check({name, ".idle_after"}, 32'(o_busy), 0);
        check({name, ".pass_held"}, 32'(o_pass), e_pass);
    endtask

    initial begin
        int w, L, d1, d2, rs;
        logic [7:0] sd;

        // Reset state
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
        check("rst.busy", 32'(o_busy), 0);
        check("rst.valid", 32'(o_valid), 0);
        check("rst.soft_reset", 32'(o_soft_reset), 0);
        check("rst.seed", 32'(o_seed), 0);
        check("rst.err", 32'(o_err), 0);
        check("rst.pass", 32'(o_pass), 0);

        run_test("nominal", 8'hAA, 100, 5, -1, -1, -1);
        run_test("zero_seed", 8'h00, 10, 3, -1, -1, -1);
        run_test("timeout", 8'h33, 10, 0, -1, -1, -1);

        // Reset from IDLE clears the held error
        i_rst = 1'b1;
        @(posedge clk); #1 i_rst = 1'b0;
        check("rst_idle.err", 32'(o_err), 0);
        check("rst_idle.pass", 32'(o_pass), 0);

        run_test("lock_loss", 8'h5C, 50, 3, 10, 30, -1);
        run_test("busy_start", 8'h3C, 20, 2, -1, -1, 8);
        run_test("zero_words", 8'h01, 0, 4, -1, -1, -1);
        run_test("lock_at_timeout", 8'h81, 3, TMO, -1, -1, -1);
        run_test("lock_after_timeout", 8'h81, 3, TMO + 1, -1, -1, -1);
        run_test("loss_first_run_cycle", 8'h7E, 6, 1, 0, -1, -1);

        // Reset mid-RUN
        i_seed = 8'hA5; i_num_words = 16'd30; i_lock = 1'b1; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("midrun.valid_before", 32'(o_valid), 1);
        i_rst = 1'b1;
        @(posedge clk); #1 i_rst = 1'b0;
        check("midrun.valid", 32'(o_valid), 0);
        check("midrun.busy", 32'(o_busy), 0);
        check("midrun.seed", 32'(o_seed), 0);
        check("midrun.err", 32'(o_err), 0);
        check("midrun.done", 32'(o_done), 0);
        @(posedge clk); #1;
        check("midrun.stays_idle", 32'(o_busy), 0);

        // Randomized requests
        for (int n = 0; n < 25; n++) begin
            sd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            w  = $urandom_range(0, 40);
            L  = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 12);
            d1 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, w + 2) : -1;
            d2 = (d1 >= 0 && $urandom_range(0, 1) == 1) ? d1 + 4 + $urandom_range(0, 10) : -1;
            rs = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : -1;
            run_test($sformatf("rand%0d", n), sd, w, L, d1, d2, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
